alu_sliced: RTL and testbench
=============================

# alu_sliced

Parametrised, multi-cycle successor to the 1-bit and 4-bit ALUs. It performs the same four operations (add, subtract, AND, OR) on WIDTH-bit operands, processing SLICE bits per clock, LSB slice first, with the carry held in a register between slices. A start/busy/done handshake wraps the operation, and the block adds registered zero and signed-overflow flags. It sits in the datapath wherever a narrow, area-cheap ALU with variable width is needed.

## Interface
- WIDTH, 8, operand/result width in bits; must be a multiple of SLICE.
- SLICE, 4, bits processed per cycle; 1 ≤ SLICE ≤ WIDTH. N = WIDTH/SLICE slice cycles.
- clk  input  1  single clock, all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- a  input  WIDTH  operand A, sampled only on an accepted start.
- b  input  WIDTH  operand B, sampled only on an accepted start.
- opcode  input  2  00 add, 01 subtract, 10 AND, 11 OR; sampled on accepted start.
- cin  input  1  carry-in for add; sampled on accepted start; ignored for other ops.
- start  input  1  request; accepted when state is IDLE or DONE.
- busy  output  1  high while in RUN.
- done  output  1  high for exactly one cycle (state DONE) when outputs are updated.
- result  output  WIDTH  registered result; holds until the next completion.
- cout  output  1  registered carry-out.
- zero  output  1  registered, result == 0.
- overflow  output  1  registered signed overflow.

## Operation
- States: IDLE, RUN, DONE. Slice counter 0..N-1, carry register, internal operand/partial-result registers.
- IDLE: start=1 → latch a, b, opcode, cin; counter=0; carry = cin (add), 1 (sub), 0 (AND/OR); → RUN.
- RUN: each cycle computes slice [k*SLICE +: SLICE] of the result from the latched operands and the carry register, writes it to the partial result, and updates the carry. At k=N-1: copy the partial result and flags to the outputs, → DONE. Otherwise k+1.
- DONE: done=1. start=1 → accept a new operation (as from IDLE) → RUN; else → IDLE.
- start in RUN is ignored; no queueing.
- Add: result = a + b + cin; cout = carry out of the MSB.
- Subtract: result = a + ~b + 1; cin is ignored. cout=1 means no borrow (a ≥ b unsigned); e.g. 1−0 gives cout=1.
- AND/OR: bitwise; cout=0, overflow=0.
- overflow (add/sub): b' = b (add) or ~b (sub); overflow = (a[MSB] == b'[MSB]) && (result[MSB] != a[MSB]).
- zero: computed on the full final result for all opcodes.
- result/cout/zero/overflow change only on the edge entering DONE; between operations they hold their values.
- Reset: state IDLE, counter 0; busy, done, result, cout, zero, overflow all 0. Reset mid-RUN aborts the operation: no done, outputs 0. Reset has priority over start.

## Timing
- Edge E0 samples start=1 in IDLE/DONE. busy=1 after E0 through E(N). Final slice written at E(N); outputs valid and done=1 in the cycle after E(N). Latency from the start edge to done is N+1 cycles.
- Back-to-back: start held in DONE at E(N+1) begins the next op; throughput is one op per N+1 cycles.
- SLICE=WIDTH gives N=1: busy one cycle, done the cycle after.
- The operand inputs may change freely after the accepting edge.

## Test plan
- WIDTH=8, SLICE=4, add a=0x96 b=0x69 cin=0 → done 3 cycles after start edge, result=0xFF, cout=0, zero=0, overflow=0; busy high exactly 2 cycles.
- Add a=0x97 b=0x69 cin=0 → result=0x00, cout=1, zero=1, overflow=0. Then add a=0x7F b=0x01 cin=0 → 0x80, overflow=1.
- Subtract a=0xFF b=0x00 cin=1 → result=0xFF, cout=1 (cin ignored). Subtract a=0x7F b=0xFF → 0x80, cout=0, overflow=1.
- AND a=0xAA b=0x0F → 0x0A, cout=0. OR a=0xA0 b=0x05 → 0xA5. OR 0x00|0x00 → 0x00, zero=1.
- start pulsed during RUN with different operands → ignored, first result unchanged. start held in DONE → next op accepted, done again N+1 cycles later. rst asserted mid-RUN → next cycle busy=0, outputs 0, no done pulse.
- WIDTH=4, SLICE=1: add 1001+0111 cin=0 → 0000, cout=1, done 5 cycles after the start edge. AND 1010&1111 → 1010.

Source files
------------

// File: rtl/alu_sliced.sv
// alu_sliced: multi-cycle ALU that processes SLICE bits per clock, LSB slice
// first, keeping the inter-slice carry in a register. Supports add, subtract,
// AND and OR on WIDTH-bit operands behind a start/busy/done handshake.
//
// Ports:
//   clk, rst        single clock, synchronous active-high reset
//   a, b            WIDTH-bit operands, captured on an accepted start
//   opcode          00 add, 01 subtract, 10 AND, 11 OR (captured on start)
//   cin             carry-in for add only (captured on start)
//   start           request; accepted in IDLE or DONE, ignored in RUN
//   busy            high while slices are being processed
//   done            one-cycle pulse when the outputs below have been updated
//   result          registered result, held until the next completion
//   cout            registered carry-out (subtract: 1 means no borrow)
//   zero            registered result == 0
//   overflow        registered signed overflow (add/subtract only)
module alu_sliced #(
    parameter int WIDTH = 8,
    parameter int SLICE = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [1:0]       opcode,
    input  logic             cin,
    input  logic             start,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             cout,
    output logic             zero,
    output logic             overflow
);

    localparam int N  = WIDTH / SLICE;
    localparam int CW = (N > 1) ? $clog2(N) : 1;

    localparam logic [1:0] OP_ADD = 2'b00;
    localparam logic [1:0] OP_SUB = 2'b01;
    localparam logic [1:0] OP_AND = 2'b10;
    localparam logic [1:0] OP_OR  = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_DONE
    } state_t;

    state_t           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             carry_q, carry_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [1:0]       op_q, op_d;
    logic [WIDTH-1:0] part_q, part_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic             cout_q, cout_d;
    logic             zero_q, zero_d;
    logic             ovf_q, ovf_d;

    // Subtract is a + ~b + 1: the inversion is applied here and the +1 comes
    // from preloading the carry register with 1 on accept.
    logic [WIDTH-1:0] b_eff;
    assign b_eff = (op_q == OP_SUB) ? ~b_q : b_q;

    logic [SLICE-1:0] a_slices [N];
    logic [SLICE-1:0] b_slices [N];
    logic [SLICE-1:0] a_sl, b_sl, slice_res;
    logic [SLICE:0]   sum_sl;
    logic             slice_cout;
    logic             last;

    // Each slice of the partial result is only rewritten in the cycle the
    // counter points at it; all other slices hold.
    generate
        for (genvar gi = 0; gi < N; gi++) begin : g_slice
            assign a_slices[gi] = a_q[gi*SLICE +: SLICE];
            assign b_slices[gi] = b_eff[gi*SLICE +: SLICE];
            assign part_d[gi*SLICE +: SLICE] =
                (state_q == ST_RUN && cnt_q == CW'(gi)) ? slice_res
                                                        : part_q[gi*SLICE +: SLICE];
        end
    endgenerate

    assign last = (cnt_q == CW'(N - 1));

    always_comb begin
        a_sl       = a_slices[cnt_q];
        b_sl       = b_slices[cnt_q];
        sum_sl     = {1'b0, a_sl} + {1'b0, b_sl} + {{SLICE{1'b0}}, carry_q};
        slice_res  = sum_sl[SLICE-1:0];
        slice_cout = sum_sl[SLICE];
        case (op_q)
            OP_AND: begin
                slice_res  = a_sl & b_sl;
                slice_cout = 1'b0;
            end
            OP_OR: begin
                slice_res  = a_sl | b_sl;
                slice_cout = 1'b0;
            end
            default: ;
        endcase
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        carry_d  = carry_q;
        a_d      = a_q;
        b_d      = b_q;
        op_d     = op_q;
        result_d = result_q;
        cout_d   = cout_q;
        zero_d   = zero_q;
        ovf_d    = ovf_q;
        case (state_q)
            ST_IDLE, ST_DONE: begin
                state_d = ST_IDLE;
                if (start) begin
                    a_d     = a;
                    b_d     = b;
                    op_d    = opcode;
                    cnt_d   = '0;
                    carry_d = (opcode == OP_ADD) ? cin : (opcode == OP_SUB);
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                carry_d = slice_cout;
                if (last) begin
                    result_d = part_d;
                    cout_d   = slice_cout;
                    zero_d   = (part_d == '0);
                    ovf_d    = (op_q == OP_ADD || op_q == OP_SUB)
                             && (a_q[WIDTH-1] == b_eff[WIDTH-1])
                             && (part_d[WIDTH-1] != a_q[WIDTH-1]);
                    state_d  = ST_DONE;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            cnt_q    <= '0;
            carry_q  <= 1'b0;
            a_q      <= '0;
            b_q      <= '0;
            op_q     <= '0;
            part_q   <= '0;
            result_q <= '0;
            cout_q   <= 1'b0;
            zero_q   <= 1'b0;
            ovf_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            carry_q  <= carry_d;
            a_q      <= a_d;
            b_q      <= b_d;
            op_q     <= op_d;
            part_q   <= part_d;
            result_q <= result_d;
            cout_q   <= cout_d;
            zero_q   <= zero_d;
            ovf_q    <= ovf_d;
        end
    end

    assign busy     = (state_q == ST_RUN);
    assign done     = (state_q == ST_DONE);
    assign result   = result_q;
    assign cout     = cout_q;
    assign zero     = zero_q;
    assign overflow = ovf_q;

endmodule

// File: tb/tb_alu_sliced.sv
// Bench for alu_sliced: instance 0 is WIDTH=8/SLICE=4, instance 1 is
// WIDTH=4/SLICE=1. A cycle-level model built on plain integer arithmetic is
// compared against both instances on every falling edge; directed operations
// also carry hand-computed expected values.
module tb_alu_sliced;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst;
    logic [7:0] in_a     [2];
    logic [7:0] in_b     [2];
    logic [1:0] in_op    [2];
    logic       in_cin   [2];
    logic       in_start [2];

    logic       busy0, done0, cout0, zero0, ovf0;
    logic [7:0] res0;
    logic       busy1, done1, cout1, zero1, ovf1;
    logic [3:0] res1;

    alu_sliced #(.WIDTH(8), .SLICE(4)) dut0 (
        .clk(clk), .rst(rst), .a(in_a[0]), .b(in_b[0]), .opcode(in_op[0]),
        .cin(in_cin[0]), .start(in_start[0]), .busy(busy0), .done(done0),
        .result(res0), .cout(cout0), .zero(zero0), .overflow(ovf0)
    );

    alu_sliced #(.WIDTH(4), .SLICE(1)) dut1 (
        .clk(clk), .rst(rst), .a(in_a[1][3:0]), .b(in_b[1][3:0]), .opcode(in_op[1]),
        .cin(in_cin[1]), .start(in_start[1]), .busy(busy1), .done(done1),
        .result(res1), .cout(cout1), .zero(zero1), .overflow(ovf1)
    );

    logic       o_busy [2];
    logic       o_done [2];
    logic [7:0] o_res  [2];
    logic       o_cout [2];
    logic       o_zero [2];
    logic       o_ovf  [2];
    assign o_busy[0] = busy0;  assign o_busy[1] = busy1;
    assign o_done[0] = done0;  assign o_done[1] = done1;
    assign o_res[0]  = res0;   assign o_res[1]  = {4'b0, res1};
    assign o_cout[0] = cout0;  assign o_cout[1] = cout1;
    assign o_zero[0] = zero0;  assign o_zero[1] = zero1;
    assign o_ovf[0]  = ovf0;   assign o_ovf[1]  = ovf1;

    int total = 0;
    int bad   = 0;
    bit chk_en = 1'b0;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, got, exp, $time);
        end
    endtask

    function automatic int n_of(input int idx);
        return (idx == 0) ? 2 : 4;
    endfunction

    function automatic int w_of(input int idx);
        return (idx == 0) ? 8 : 4;
    endfunction

    // Reference arithmetic from integer semantics: packed {cout, ovf, zero, result}.
    function automatic logic [10:0] calc(input logic [7:0] a, input logic [7:0] b,
                                         input logic [1:0] op, input logic cin, input int w);
        longint mask, ua, ub, sa, sb, s, full, r, half;
        bit co, ov, z;
        logic [7:0] r8;
        mask = (longint'(1) << w) - 1;
        half = longint'(1) << (w - 1);
        ua   = longint'(a) & mask;
        ub   = longint'(b) & mask;
        sa   = (ua >= half) ? ua - (longint'(1) << w) : ua;
        sb   = (ub >= half) ? ub - (longint'(1) << w) : ub;
        s    = 0;
        case (op)
            2'd0: begin full = ua + ub + longint'(cin); s = sa + sb + longint'(cin); end
            2'd1: begin full = ua + (mask - ub) + 1;    s = sa - sb;                end
            2'd2: full = ua & ub;
            default: full = ua | ub;
        endcase
        r  = full & mask;
        co = (op <= 2'd1) && (((full >> w) & 1) != 0);
        ov = (op <= 2'd1) && ((s > half - 1) || (s < -half));
        z  = (r == 0);
        r8 = r[7:0];
        return {co, ov, z, r8};
    endfunction

    // Cycle model: an accepted op keeps the unit busy for N cycles, then the
    // outputs take the computed value and done is high for one cycle.
    int          m_left [2] = '{0, 0};
    bit          m_done [2] = '{0, 0};
    logic [10:0] m_pend [2] = '{11'd0, 11'd0};
    logic [10:0] m_out  [2] = '{11'd0, 11'd0};

    always @(posedge clk) begin
        for (int i = 0; i < 2; i++) begin
            if (rst) begin
                m_left[i] <= 0;
                m_done[i] <= 1'b0;
                m_out[i]  <= '0;
            end else if (m_left[i] == 0) begin
                m_done[i] <= 1'b0;
                if (in_start[i]) begin
                    m_pend[i] <= calc(in_a[i], in_b[i], in_op[i], in_cin[i], w_of(i));
                    m_left[i] <= n_of(i);
                end
            end else begin
                m_left[i] <= m_left[i] - 1;
                if (m_left[i] == 1) begin
                    m_done[i] <= 1'b1;
                    m_out[i]  <= m_pend[i];
                end
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            for (int i = 0; i < 2; i++) begin
                chk($sformatf("model_busy%0d", i), 32'(o_busy[i]), 32'(m_left[i] != 0));
                chk($sformatf("model_done%0d", i), 32'(o_done[i]), 32'(m_done[i]));
                chk($sformatf("model_result%0d", i), 32'(o_res[i]), 32'(m_out[i][7:0]));
                chk($sformatf("model_zero%0d", i), 32'(o_zero[i]), 32'(m_out[i][8]));
                chk($sformatf("model_ovf%0d", i), 32'(o_ovf[i]), 32'(m_out[i][9]));
                chk($sformatf("model_cout%0d", i), 32'(o_cout[i]), 32'(m_out[i][10]));
            end
        end
    end

    // Call right after a falling edge. Launches one op, scrambles operands
    // afterwards, optionally pulses start again during RUN, and returns on the
    // falling edge where done is seen.
    task automatic do_op(input int idx, input logic [7:0] a, input logic [7:0] b,
                         input logic [1:0] op, input logic cin,
                         input logic [7:0] exp_r, input logic exp_c, input logic exp_z,
                         input logic exp_v, input bit glitch, input string tag);
        int  lat;
        int  busy_n;
        bit  seen;
        lat = 0; busy_n = 0; seen = 1'b0;
        in_a[idx] = a; in_b[idx] = b; in_op[idx] = op; in_cin[idx] = cin;
        in_start[idx] = 1'b1;
        while (!seen && lat < 20) begin
            @(negedge clk);
            lat++;
            if (o_done[idx]) begin
                seen = 1'b1;
            end else begin
                if (o_busy[idx]) busy_n++;
                if (lat == 1) begin
                    in_a[idx]     = 8'($urandom);
                    in_b[idx]     = 8'($urandom);
                    in_op[idx]    = 2'($urandom);
                    in_cin[idx]   = 1'($urandom);
                    in_start[idx] = glitch;
                end else begin
                    in_start[idx] = 1'b0;
                end
            end
        end
        chk({tag, "_seen"}, 32'(seen), 32'd1);
        if (seen) begin
            $display("op %s dut%0d a=%h b=%h op=%0d cin=%0d -> result=%h cout=%0d zero=%0d ovf=%0d lat=%0d",
                     tag, idx, a, b, op, cin, o_res[idx], o_cout[idx], o_zero[idx], o_ovf[idx], lat);
            chk({tag, "_lat"}, 32'(lat), 32'(n_of(idx) + 1));
            chk({tag, "_busy_cycles"}, 32'(busy_n), 32'(n_of(idx)));
            chk({tag, "_result"}, 32'(o_res[idx]), 32'(exp_r));
            chk({tag, "_cout"}, 32'(o_cout[idx]), 32'(exp_c));
            chk({tag, "_zero"}, 32'(o_zero[idx]), 32'(exp_z));
            chk({tag, "_ovf"}, 32'(o_ovf[idx]), 32'(exp_v));
        end
    endtask

    initial begin
        rst = 1'b1;
        for (int i = 0; i < 2; i++) begin
            in_a[i] = '0; in_b[i] = '0; in_op[i] = '0; in_cin[i] = 1'b0; in_start[i] = 1'b0;
        end
        repeat (3) @(negedge clk);
        rst = 1'b0;
        chk_en = 1'b1;
        chk("reset_busy", 32'(busy0), 32'd0);
        chk("reset_done", 32'(done0), 32'd0);
        chk("reset_result", 32'(res0), 32'd0);
        chk("reset_flags", {29'd0, cout0, zero0, ovf0}, 32'd0);
        @(negedge clk);

        do_op(0, 8'h96, 8'h69, 2'd0, 1'b0, 8'hFF, 1'b0, 1'b0, 1'b0, 1'b0, "add_ff");
        @(negedge clk);
        do_op(0, 8'h97, 8'h69, 2'd0, 1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 1'b0, "add_wrap");
        @(negedge clk);
        do_op(0, 8'h7F, 8'h01, 2'd0, 1'b0, 8'h80, 1'b0, 1'b0, 1'b1, 1'b0, "add_ovf");
        @(negedge clk);
        do_op(0, 8'hFF, 8'h00, 2'd1, 1'b1, 8'hFF, 1'b1, 1'b0, 1'b0, 1'b0, "sub_cin_ign");
        @(negedge clk);
        do_op(0, 8'h7F, 8'hFF, 2'd1, 1'b0, 8'h80, 1'b0, 1'b0, 1'b1, 1'b0, "sub_ovf");
        @(negedge clk);
        do_op(0, 8'hAA, 8'h0F, 2'd2, 1'b1, 8'h0A, 1'b0, 1'b0, 1'b0, 1'b0, "and");
        @(negedge clk);
        do_op(0, 8'hA0, 8'h05, 2'd3, 1'b0, 8'hA5, 1'b0, 1'b0, 1'b0, 1'b0, "or");
        @(negedge clk);
        do_op(0, 8'h00, 8'h00, 2'd3, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0, "or_zero");
        @(negedge clk);
        do_op(0, 8'h12, 8'h34, 2'd0, 1'b1, 8'h47, 1'b0, 1'b0, 1'b0, 1'b1, "start_in_run");
        @(negedge clk);
        // Back-to-back: the second op is launched on the done cycle of the first.
        do_op(0, 8'h50, 8'h30, 2'd1, 1'b0, 8'h20, 1'b1, 1'b0, 1'b0, 1'b0, "chain_a");
        do_op(0, 8'h80, 8'h80, 2'd0, 1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 1'b0, "chain_b");
        @(negedge clk);

        // Reset one cycle into RUN: operation is dropped, outputs cleared.
        in_a[0] = 8'hF0; in_b[0] = 8'h0F; in_op[0] = 2'd0; in_cin[0] = 1'b1; in_start[0] = 1'b1;
        @(negedge clk);
        in_start[0] = 1'b0;
        chk("abort_busy_before", 32'(busy0), 32'd1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("abort_busy", 32'(busy0), 32'd0);
        chk("abort_done", 32'(done0), 32'd0);
        chk("abort_result", 32'(res0), 32'd0);
        chk("abort_flags", {29'd0, cout0, zero0, ovf0}, 32'd0);
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            chk("abort_no_done", 32'(done0), 32'd0);
        end
        $display("op abort dut0 reset mid-run -> busy=%0d done=%0d result=%h", busy0, done0, res0);

        do_op(1, 8'h09, 8'h07, 2'd0, 1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 1'b0, "w4_add");
        @(negedge clk);
        do_op(1, 8'h0A, 8'h0F, 2'd2, 1'b0, 8'h0A, 1'b0, 1'b0, 1'b0, 1'b0, "w4_and");
        do_op(1, 8'h03, 8'h05, 2'd1, 1'b0, 8'h0E, 1'b0, 1'b0, 1'b0, 1'b0, "w4_sub");
        repeat (2) @(negedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
